// File: rtl/seg7_mux_display_if.sv
// Bus between the display driver and its host: value/load request in, status and pin drive out.
// The host (master) drives number/load; the driver (slave) returns busy/overflow and the pin signals.
interface seg7_mux_display_if #(
    parameter int NUM_DIGITS = 4,
    parameter int DATA_WIDTH = 14
);
    logic [DATA_WIDTH-1:0] number;
    logic                  load;
    logic                  busy;
    logic                  overflow;
    logic [6:0]            seg7;
    logic [NUM_DIGITS-1:0] select;

    modport master (output number, load, input busy, overflow, seg7, select);
    modport slave  (input number, load, output busy, overflow, seg7, select);
endinterface

// File: rtl/seg7_mux_display.sv
// N-digit multiplexed 7-segment driver: sequential double-dabble conversion plus registered digit scan.
// Optional feature macro: LEADING_ZERO_BLANK_EN (blank zero digits above the most significant nonzero one).
module seg7_mux_display #(
    parameter int NUM_DIGITS = 4,
    parameter int DATA_WIDTH = 14
) (
    input  logic               slow_clk,
    input  logic               reset,
    seg7_mux_display_if.slave  bus
);
    localparam int DISP_W = 4 * NUM_DIGITS;
    localparam int BCD_W  = DISP_W + 4;
    localparam int IDX_W  = $clog2(NUM_DIGITS);
    localparam int CNT_W  = $clog2(DATA_WIDTH) + 1;
    localparam longint unsigned LIMIT = 64'(10 ** NUM_DIGITS);
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

    state_t              state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [BCD_W-1:0]    bcd_q, bcd_adj;
    logic [CNT_W-1:0]    cnt_q;
    logic                big_q;
    logic [DISP_W-1:0]   digits_q;
    logic [IDX_W-1:0]    idx_q;
    logic [NUM_DIGITS-1:0] blank;
    logic [3:0]          cur_digit;

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0: decode = 7'h40;
            4'd1: decode = 7'h79;
            4'd2: decode = 7'h24;
            4'd3: decode = 7'h30;
            4'd4: decode = 7'h19;
            4'd5: decode = 7'h12;
            4'd6: decode = 7'h02;
            4'd7: decode = 7'h78;
            4'd8: decode = 7'h00;
            4'd9: decode = 7'h10;
            default: decode = SEG_BLANK;
        endcase
    endfunction

    always_ff @(posedge slow_clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.load) state_d = SHIFT;
            SHIFT:   if (cnt_q == CNT_W'(DATA_WIDTH - 1)) state_d = COMMIT;
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Double-dabble correction: any nibble >= 5 gets +3 before the shift.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < NUM_DIGITS + 1; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge slow_clk or posedge reset) begin
        if (reset) begin
            shift_q      <= '0;
            bcd_q        <= '0;
            cnt_q        <= '0;
            big_q        <= 1'b0;
            digits_q     <= '0;
            bus.busy     <= 1'b0;
            bus.overflow <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (bus.load) begin
                    shift_q  <= bus.number;
                    bcd_q    <= '0;
                    cnt_q    <= '0;
                    big_q    <= (64'(bus.number) >= LIMIT);
                    bus.busy <= 1'b1;
                end
                SHIFT: begin
                    {bcd_q, shift_q} <= {bcd_adj[BCD_W-2:0], shift_q, 1'b0};
                    if (bcd_adj[BCD_W-1]) big_q <= 1'b1;
                    cnt_q <= cnt_q + 1'b1;
                end
                COMMIT: begin
                    digits_q     <= bcd_q[DISP_W-1:0];
                    bus.overflow <= big_q | (|bcd_q[BCD_W-1:DISP_W]);
                    bus.busy     <= 1'b0;
                end
                default: ;
            endcase
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic seen;
    always_comb begin
        seen  = 1'b0;
        blank = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            seen     = seen | (digits_q[4*i +: 4] != 4'd0);
            blank[i] = ~seen;
        end
    end
`else
    assign blank = '0;
`endif

    assign cur_digit = digits_q[{idx_q, 2'b00} +: 4];

    // Scan runs free of the converter; outputs for idx land one edge after idx.
    always_ff @(posedge slow_clk or posedge reset) begin
        if (reset) begin
            idx_q      <= '0;
            bus.select <= '1;
            bus.seg7   <= SEG_BLANK;
        end else begin
            idx_q      <= (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
            bus.select <= ~(NUM_DIGITS'(1) << idx_q);
            if (bus.overflow)      bus.seg7 <= SEG_DASH;
            else if (blank[idx_q]) bus.seg7 <= SEG_BLANK;
            else                   bus.seg7 <= decode(cur_digit);
        end
    end
endmodule

// File: tb/tb_seg7_mux_display.sv
// Directed bench for seg7_mux_display: default 4-digit/14-bit instance plus a 3-digit/8-bit instance.
// Outputs are sampled on the falling edge; expected segment codes are hand-written constants.
module tb_seg7_mux_display;
    logic slow_clk;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    seg7_mux_display_if #(.NUM_DIGITS(4), .DATA_WIDTH(14)) if_a ();
    seg7_mux_display_if #(.NUM_DIGITS(3), .DATA_WIDTH(8))  if_b ();

    seg7_mux_display #(.NUM_DIGITS(4), .DATA_WIDTH(14)) dut_a (
        .slow_clk (slow_clk),
        .reset    (reset),
        .bus      (if_a.slave)
    );
    seg7_mux_display #(.NUM_DIGITS(3), .DATA_WIDTH(8)) dut_b (
        .slow_clk (slow_clk),
        .reset    (reset),
        .bus      (if_b.slave)
    );

    localparam logic [6:0] S0 = 7'h40, S1 = 7'h79, S2 = 7'h24, S3 = 7'h30, S4 = 7'h19;
    localparam logic [6:0] S5 = 7'h12, S6 = 7'h02, S7 = 7'h78, S8 = 7'h00, S9 = 7'h10;
    localparam logic [6:0] SB = 7'h7F, SD = 7'h3F;
`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [6:0] LZ = SB;
`else
    localparam logic [6:0] LZ = S0;
`endif

    initial begin
        slow_clk = 1'b0;
        forever #5 slow_clk = ~slow_clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input int which, input logic [31:0] v, input logic ld);
        if (which == 0) begin if_a.number = v[13:0]; if_a.load = ld; end
        else            begin if_b.number = v[7:0];  if_b.load = ld; end
    endtask

    function automatic logic busy_of(input int which);
        return (which == 0) ? if_a.busy : if_b.busy;
    endfunction

    // Load v, then count falling edges on which busy is seen high; optionally pulse a rogue load mid-way.
    task automatic load_dut(input int which, input logic [31:0] v, input bit inject, output int cyc);
        @(negedge slow_clk);
        drive(which, v, 1'b1);
        @(negedge slow_clk);
        drive(which, ~v, 1'b0);
        cyc = 0;
        while (busy_of(which) && cyc < 100) begin
            cyc++;
            if (inject && cyc == 5) drive(which, 32'd4321, 1'b1);
            else                    drive(which, ~v, 1'b0);
            @(negedge slow_clk);
        end
        drive(which, ~v, 1'b0);
    endtask

    // Sample n+1 scan slots: exactly one select low, positions advance by one and wrap, seg7 matches.
    task automatic scan_check(input string tag, input int which, input int n,
                              input logic [6:0] e0, input logic [6:0] e1,
                              input logic [6:0] e2, input logic [6:0] e3);
        logic [6:0] exp [4];
        logic [7:0] sel;
        logic [6:0] sg;
        int prev, pos, zeros;
        exp[0] = e0; exp[1] = e1; exp[2] = e2; exp[3] = e3;
        prev = -1;
        for (int k = 0; k <= n; k++) begin
            @(negedge slow_clk);
            sel = (which == 0) ? 8'(if_a.select) : 8'(if_b.select);
            sg  = (which == 0) ? if_a.seg7 : if_b.seg7;
            zeros = 0;
            pos = -1;
            for (int i = 0; i < n; i++) if (!sel[i]) begin zeros++; pos = i; end
            check($sformatf("%s_sel_onehot", tag), 32'(zeros), 32'd1);
            if (zeros == 1) begin
                if (prev >= 0) check($sformatf("%s_scan_order", tag), 32'(pos), 32'((prev + 1) % n));
                check($sformatf("%s_seg_pos%0d", tag, pos), 32'(sg), 32'(exp[pos]));
                prev = pos;
            end
        end
    endtask

    initial begin
        int cyc;
        reset = 1'b1;
        drive(0, 0, 1'b0);
        drive(1, 0, 1'b0);
        #1;
        check("rst_seg7",     32'(if_a.seg7),     32'h7F);
        check("rst_select",   32'(if_a.select),   32'hF);
        check("rst_busy",     32'(if_a.busy),     32'd0);
        check("rst_overflow", 32'(if_a.overflow), 32'd0);
        repeat (2) @(negedge slow_clk);
        reset = 1'b0;

        load_dut(0, 1234, 1'b0, cyc);
        check("busy_len_1234", 32'(cyc), 32'd15);
        check("ovf_1234", 32'(if_a.overflow), 32'd0);
        scan_check("n1234", 0, 4, S4, S3, S2, S1);

        load_dut(0, 9999, 1'b0, cyc);
        check("ovf_9999", 32'(if_a.overflow), 32'd0);
        scan_check("n9999", 0, 4, S9, S9, S9, S9);

        load_dut(0, 10000, 1'b0, cyc);
        check("ovf_10000", 32'(if_a.overflow), 32'd1);
        scan_check("n10000", 0, 4, SD, SD, SD, SD);

        load_dut(0, 7, 1'b0, cyc);
        check("ovf_7", 32'(if_a.overflow), 32'd0);
        scan_check("n7", 0, 4, S7, LZ, LZ, LZ);

        load_dut(0, 5678, 1'b1, cyc);
        check("busy_len_inject", 32'(cyc), 32'd15);
        scan_check("n5678", 0, 4, S8, S7, S6, S5);

        load_dut(1, 255, 1'b0, cyc);
        check("b_busy_len", 32'(cyc), 32'd9);
        check("b_ovf_255", 32'(if_b.overflow), 32'd0);
        scan_check("b255", 1, 3, S5, S5, S2, SB);

        // Async reset in the middle of a conversion.
        @(negedge slow_clk);
        drive(0, 1234, 1'b1);
        @(negedge slow_clk);
        drive(0, 0, 1'b0);
        repeat (3) @(negedge slow_clk);
        #2 reset = 1'b1;
        #1;
        check("midrst_busy",   32'(if_a.busy),   32'd0);
        check("midrst_seg7",   32'(if_a.seg7),   32'h7F);
        check("midrst_select", 32'(if_a.select), 32'hF);
        @(negedge slow_clk);
        reset = 1'b0;
        repeat (20) @(negedge slow_clk);
        check("postrst_busy", 32'(if_a.busy), 32'd0);
        scan_check("postrst", 0, 4, S0, LZ, LZ, LZ);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
